// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the control decode stage: control word layout,
// opcode values, field encodings and the stage state enum.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LUI   = 2'b11;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  typedef struct packed {
    logic       branch;
    logic [1:0] jump;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       alu_a_pc;
    logic       illegal;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode-to-control decode. DECODE_ILLEGAL_TRAP_EN selects whether
// unknown opcodes produce an illegal-only word or fall back to R-type.
module opcode_decoder
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl
);

  logic [6:0] opcode;
  logic       unused_hi;

  assign opcode    = instr[6:0];
  assign unused_hi = ^instr[INSTR_W-1:25];

  always_comb begin
    ctrl        = '0;
    ctrl.funct3 = instr[14:12];
    ctrl.rd     = instr[11:7];
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write = 1'b1; ctrl.imm_src = IMM_I; ctrl.alu_src = 1'b1;
        ctrl.result_src = RES_MEM; ctrl.alu_op = ALU_ADD;
      end
      OP_STORE: begin
        ctrl.imm_src = IMM_S; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        ctrl.alu_op = ALU_ADD;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.imm_src = IMM_B; ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB;
      end
      OP_IALU: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_FUNCT;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1; ctrl.imm_src = IMM_J; ctrl.result_src = RES_PC4;
        ctrl.jump = JMP_JAL;
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.result_src = RES_PC4;
        ctrl.alu_op = ALU_FUNCT; ctrl.jump = JMP_JALR;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1; ctrl.imm_src = IMM_U; ctrl.alu_src = 1'b1;
        ctrl.result_src = RES_IMM; ctrl.alu_op = ALU_LUI;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1; ctrl.imm_src = IMM_U; ctrl.alu_src = 1'b1;
        ctrl.alu_op = ALU_ADD; ctrl.alu_a_pc = 1'b1;
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        // Trap word carries no side effects; register fields are cleared too.
        ctrl         = '0;
        ctrl.illegal = 1'b1;
`else
        ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_FUNCT;
`endif
      end
    endcase
  end

endmodule

// File: rtl/control_decode_stage.sv
// Decode stage: decodes each accepted instruction and queues it in a small FIFO.
// With DECODE_ILLEGAL_TRAP_EN defined, an illegal push halts intake until flush.
module control_decode_stage
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output ctrl_t              ctrl_o,
  output logic [ADDR_W-1:0]  pc_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  ctrl_t             ctrl_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;
  state_t            state;
  ctrl_t             dec;
  logic              push, pop;

  opcode_decoder #(.INSTR_W(INSTR_W)) u_dec (
    .instr (instr_i),
    .ctrl  (dec)
  );

  assign out_valid_o = (count != '0);
  assign pop         = out_valid_o && out_ready_i;
  // A same-cycle pop frees a slot, so a full buffer can still accept.
  assign in_ready_o  = (count < FULL || pop) && state == RUN && !flush_i;
  assign push        = in_valid_i && in_ready_o;
  assign ctrl_o      = out_valid_o ? ctrl_mem[rptr] : '0;
  assign pc_o        = out_valid_o ? pc_mem[rptr]   : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      state <= RUN;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (push && dec.illegal) state <= HALT;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      ctrl_mem[wptr] <= dec;
      pc_mem[wptr]   <= pc_i;
    end
  end

endmodule
